// File: rtl/capture_buffer_if.sv
// ---------------------------------------------------------------
// capture_buffer_if: aligner-side sample stream and consumer-side head stream
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface capture_buffer_if #(
  parameter int WIDTH = 24
);
  logic             ready_i;
  logic             valid_i;
  logic             error_i;
  logic [WIDTH-1:0] data_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_last_o;

  modport master (
    output ready_i, valid_i, error_i, data_i, m_ready_i,
    input  m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    input  ready_i, valid_i, error_i, data_i, m_ready_i,
    output m_valid_o, m_data_o, m_last_o
  );
endinterface

`default_nettype wire

// File: rtl/capture_buffer.sv
// ---------------------------------------------------------------
// capture_buffer: lock-gated sample capture into a show-ahead FIFO
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module capture_buffer #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int ABITS = 4,
  parameter int BLOCK = 32,
  parameter int BBITS = 5
) (
  input  wire logic          clock_i,
  input  wire logic          reset_ni,
  input  wire logic          enable_i,
  input  wire logic          clear_i,
  capture_buffer_if.slave    bus,
  output logic [ABITS:0]     level_o,
  output logic               overflow_o,
  output logic [7:0]         drops_o,
  output logic               error_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [BBITS-1:0] c_frame_last = BBITS'(BLOCK - 1);

  state_t           r_state;
  logic [BBITS-1:0] r_frame;
  logic [ABITS:0]   r_wr_ptr;
  logic [ABITS:0]   r_rd_ptr;
  logic [WIDTH:0]   r_mem [DEPTH];
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_last;
  logic             r_overflow;
  logic [7:0]       r_drops;
  logic             r_error;

  logic             w_full;
  logic             w_pop;
  logic             w_lock_lost;
  logic             w_attempt;
  logic             w_accept;
  logic             w_drop;
  logic             w_last;
  logic [ABITS:0]   w_rd_next;
  logic             w_head_next;

  assign w_full      = (r_wr_ptr[ABITS] != r_rd_ptr[ABITS]) &&
                       (r_wr_ptr[ABITS-1:0] == r_rd_ptr[ABITS-1:0]);
  assign w_pop       = r_m_valid && bus.m_ready_i;
  assign w_lock_lost = bus.error_i || !bus.valid_i;
  assign w_attempt   = enable_i && (r_state == ST_RUN) && !w_lock_lost && bus.ready_i;
  assign w_accept    = w_attempt && (!w_full || w_pop);
  assign w_drop      = w_attempt && !w_accept;
  assign w_last      = (r_frame == c_frame_last);
  assign w_rd_next   = r_rd_ptr + {{ABITS{1'b0}}, w_pop};
  // Compared against the pre-edge write pointer so a fresh write is never bypassed.
  assign w_head_next = (r_wr_ptr != w_rd_next);

  always_ff @(posedge clock_i) begin
    if (w_accept) begin
      r_mem[r_wr_ptr[ABITS-1:0]] <= {w_last, bus.data_i};
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + {{ABITS{1'b0}}, w_accept};
      r_rd_ptr  <= w_rd_next;
      r_m_valid <= w_head_next;
      if (w_head_next) begin
        {r_m_last, r_m_data} <= r_mem[w_rd_next[ABITS-1:0]];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
    end else begin
      if (!enable_i) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_WAIT;
          ST_WAIT: if (!w_lock_lost) r_state <= ST_RUN;
          ST_RUN:  if (w_lock_lost)  r_state <= ST_HALT;
          ST_HALT: if (clear_i)      r_state <= ST_WAIT;
          default: r_state <= ST_IDLE;
        endcase
      end
      // Rejected attempts still advance the count to keep frames aligned to sample time.
      if (!enable_i || (r_state != ST_RUN) || w_lock_lost) begin
        r_frame <= '0;
      end else if (bus.ready_i) begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_overflow <= 1'b0;
      r_drops    <= '0;
      r_error    <= 1'b0;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_drops    <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != 8'hFF) begin
          r_drops <= r_drops + 8'd1;
        end
      end
      if (enable_i && (r_state == ST_RUN) && w_lock_lost) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.m_valid_o = r_m_valid;
  assign bus.m_data_o  = r_m_data;
  assign bus.m_last_o  = r_m_last;
  assign level_o       = r_wr_ptr - r_rd_ptr;
  assign overflow_o    = r_overflow;
  assign drops_o       = r_drops;
  assign error_o       = r_error;
  assign state_o       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_capture_buffer.sv
// ---------------------------------------------------------------
// tb_capture_buffer: directed and random stimulus against a queue-based model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_capture_buffer;
  localparam int WIDTH = 24;
  localparam int DEPTH = 16;
  localparam int ABITS = 4;
  localparam int BLOCK = 32;
  localparam int BBITS = 5;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       enable;
  logic       clear;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drops;
  logic       error;
  logic [1:0] state;

  capture_buffer_if #(.WIDTH(WIDTH)) bus ();

  capture_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ABITS(ABITS), .BLOCK(BLOCK), .BBITS(BBITS)
  ) dut (
    .clock_i    (clk),
    .reset_ni   (reset_ni),
    .enable_i   (enable),
    .clear_i    (clear),
    .bus        (bus),
    .level_o    (level),
    .overflow_o (overflow),
    .drops_o    (drops),
    .error_o    (error),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: queue of entries stamped with the edge that wrote them.
  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
    int               s;
  } ent_t;

  ent_t q[$];
  ent_t e;
  int   m_state, m_frame, m_drops, cyc;
  bit   m_ovf, m_err, exp_valid, lost, att;

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      q.delete();
      m_state = 0; m_frame = 0; m_drops = 0; cyc = 0;
      m_ovf = 0; m_err = 0; exp_valid = 0;
    end else begin
      cyc++;
      if (exp_valid && bus.m_ready_i) void'(q.pop_front());
      lost = bus.error_i || !bus.valid_i;
      att  = 0;
      if (!enable) m_state = 0;
      else begin
        case (m_state)
          0: m_state = 1;
          1: if (!lost) m_state = 2;
          2: if (lost) begin m_state = 3; m_err = 1; end else att = bus.ready_i;
          default: if (clear) m_state = 1;
        endcase
      end
      if (att) begin
        e.d = bus.data_i;
        e.l = (m_frame == BLOCK - 1);
        e.s = cyc;
        m_frame = (m_frame + 1) % BLOCK;
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end else if (m_state != 2) begin
        m_frame = 0;
      end
      if (clear) begin m_ovf = 0; m_drops = 0; m_err = 0; end
      exp_valid = (q.size() > 0) && (q[0].s < cyc);
    end
  end

  always @(negedge clk) begin
    if (reset_ni) begin
      chk("m_valid", bus.m_valid_o, exp_valid);
      if (exp_valid && bus.m_valid_o)
        chk("head", {bus.m_last_o, bus.m_data_o}, {q[0].l, q[0].d});
      chk("level", level, q.size());
      chk("overflow", overflow, m_ovf);
      chk("drops", drops, m_drops);
      chk("error", error, m_err);
      chk("state", state, m_state);
    end
  end

  logic [WIDTH:0] rec[$];
  int             maxlev;

  always @(negedge clk) begin
    if (reset_ni) begin
      if (bus.m_valid_o && bus.m_ready_i) rec.push_back({bus.m_last_o, bus.m_data_o});
      if (int'(level) > maxlev) maxlev = int'(level);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(logic [WIDTH-1:0] d, int gap);
    bus.ready_i = 1'b1;
    bus.data_i  = d;
    tick(1);
    bus.ready_i = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  initial begin
    reset_ni = 1'b0; enable = 1'b0; clear = 1'b0;
    bus.ready_i = 1'b0; bus.valid_i = 1'b0; bus.error_i = 1'b0;
    bus.data_i = '0; bus.m_ready_i = 1'b0;
    maxlev = 0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_m_valid", bus.m_valid_o, 0);
    chk("rst_level", level, 0);
    chk("rst_flags", {overflow, error, drops}, 0);
    chk("rst_head", {bus.m_last_o, bus.m_data_o}, 0);
    tick(1);
    reset_ni = 1'b1;

    // Basic stream
    enable = 1'b1; bus.valid_i = 1'b1; bus.m_ready_i = 1'b1;
    tick(3);
    chk("run_entry", state, 2);
    maxlev = 0;
    rec.delete();
    for (int i = 1; i <= 64; i++) strobe(WIDTH'(i), 11);
    chk("basic_count", rec.size(), 64);
    for (int i = 0; i < 64 && i < rec.size(); i++)
      chk("basic_out", rec[i], {(i == 31 || i == 63), WIDTH'(i + 1)});
    chk("basic_maxlev", maxlev <= 1, 1);

    // Overflow
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) strobe(WIDTH'(32'h41 + i), 0);
    tick(2);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drops, 4);

    // Full with simultaneous pop
    rec.delete();
    bus.m_ready_i = 1'b1;
    strobe(24'h000099, 0);
    bus.m_ready_i = 1'b0;
    tick(1);
    chk("fullpop_level", level, 16);
    chk("fullpop_drops", drops, 4);

    // Drain
    bus.m_ready_i = 1'b1;
    tick(40);
    chk("drain_count", rec.size(), 17);
    for (int i = 0; i < 16 && i < rec.size(); i++)
      chk("drain_out", rec[i], {1'b0, WIDTH'(32'h41 + i)});
    if (rec.size() > 16) chk("drain_tail", rec[16], {1'b0, 24'h000099});

    // Loss of lock
    rec.delete();
    for (int i = 0; i < 10; i++) strobe(WIDTH'(32'h200 + i), 1);
    bus.error_i = 1'b1;
    tick(1);
    bus.error_i = 1'b0;
    chk("halt_state", state, 3);
    chk("halt_error", error, 1);
    for (int i = 0; i < 3; i++) strobe(24'hBAD000, 1);
    tick(3);
    chk("halt_ignored", rec.size(), 10);
    chk("halt_level", level, 0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_wait", state, 1);
    chk("clear_error", error, 0);
    tick(1);
    chk("rerun", state, 2);
    rec.delete();
    for (int i = 0; i < 32; i++) strobe(WIDTH'(32'h100 + i), 1);
    tick(4);
    chk("frame_count", rec.size(), 32);
    for (int i = 0; i < 32 && i < rec.size(); i++)
      chk("frame_out", rec[i], {(i == 31), WIDTH'(32'h100 + i)});

    // Drop counter saturation and clear
    bus.m_ready_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 316; i++) begin
      bus.data_i = WIDTH'($urandom);
      tick(1);
    end
    bus.ready_i = 1'b0;
    tick(1);
    chk("sat_drops", drops, 255);
    chk("sat_level", level, 16);
    bus.ready_i = 1'b1;
    clear = 1'b1;
    tick(1);
    bus.ready_i = 1'b0;
    clear = 1'b0;
    chk("clrdrop_drops", drops, 0);
    chk("clrdrop_ovf", overflow, 0);

    // Mid-frame asynchronous reset
    bus.m_ready_i = 1'b1;
    tick(20);
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) strobe(WIDTH'(32'h300 + i), 0);
    tick(2);
    chk("pre_rst_level", level, 5);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("arst_m_valid", bus.m_valid_o, 0);
    chk("arst_level", level, 0);
    chk("arst_state", state, 0);
    tick(2);
    reset_ni = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom % 50) != 0;
      bus.valid_i   = ($urandom % 30) != 0;
      bus.error_i   = ($urandom % 40) == 0;
      clear         = ($urandom % 25) == 0;
      bus.ready_i   = ($urandom % 3) != 0;
      bus.m_ready_i = ($urandom % 2) != 0;
      bus.data_i    = WIDTH'($urandom);
      tick(1);
    end
    bus.ready_i = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
